// File: rtl/turn_controller_pkg.sv
// Shared types, piece constants and board helpers for the turn controller.
package turn_controller_pkg;

  typedef enum logic [1:0] {
    START_SCREEN,
    CHESS_SCREEN,
    END_SCREEN
  } screen_state_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MOVE,
    APPLY,
    SEND,
    GAME_END
  } turn_ctrl_state_t;

  localparam logic [3:0] PIECE_EMPTY  = 4'd15;
  localparam logic [3:0] PAWN         = 4'd0;
  localparam logic [3:0] QUEEN        = 4'd4;
  localparam logic [3:0] KING         = 4'd5;
  localparam logic [3:0] SIDE0_OFFSET = 4'd6;

  // Indexed [x][y]: x is rank, y is file.
  typedef logic [3:0] board_t [8][8];

  // Back-rank piece for side 1 on file y.
  function automatic logic [3:0] back_piece(input logic [2:0] y);
    logic [3:0] p;
    unique case (y)
      3'd0, 3'd7: p = 4'd3;
      3'd1, 3'd6: p = 4'd1;
      3'd2, 3'd5: p = 4'd2;
      3'd3:       p = QUEEN;
      default:    p = KING;
    endcase
    return p;
  endfunction

  function automatic board_t init_board();
    board_t b;
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        b[x][y] = PIECE_EMPTY;
      end
    end
    for (int y = 0; y < 8; y++) begin
      b[0][y] = back_piece(y[2:0]);
      b[1][y] = PAWN;
      b[6][y] = PAWN + SIDE0_OFFSET;
      b[7][y] = back_piece(y[2:0]) + SIDE0_OFFSET;
    end
    return b;
  endfunction

  // Side 1 owns codes 0-5, side 0 owns codes 6-11.
  function automatic logic owns_piece(input logic [3:0] piece, input logic side);
    if (side) begin
      return piece <= KING;
    end
    return (piece >= SIDE0_OFFSET) && (piece <= KING + SIDE0_OFFSET);
  endfunction

endpackage

// File: rtl/turn_controller_turn_timer.sv
// Per-turn countdown: a CLK_HZ prescaler feeding a whole-second counter.
module turn_timer #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TURN_SECONDS = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       run,
  input  logic       reload,
  output logic [7:0] turn_time,
  output logic       expired
);

  localparam logic [31:0] PRESCALE_MAX = 32'(CLK_HZ - 1);
  localparam logic [7:0]  TURN_RELOAD  = 8'(TURN_SECONDS);

  logic [31:0] prescaler;

  // Reload wins over counting; the second counter saturates at zero.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      turn_time <= TURN_RELOAD;
    end else if (reload) begin
      prescaler <= '0;
      turn_time <= TURN_RELOAD;
    end else if (run) begin
      if (prescaler == PRESCALE_MAX) begin
        prescaler <= '0;
        if (turn_time != 8'd0) begin
          turn_time <= turn_time - 8'd1;
        end
      end else begin
        prescaler <= prescaler + 32'd1;
      end
    end
  end

  assign expired = (turn_time == 8'd0);

endmodule

// File: rtl/turn_controller.sv
// Owns the authoritative board and turn token; applies one move per turn.
module turn_controller
  import turn_controller_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TURN_SECONDS = 60
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          player,
  input  screen_state_t sys_state,
  input  logic          local_moved,
  input  logic [11:0]   local_packet,
  input  logic          rx_valid,
  input  logic [11:0]   rx_packet,
  output logic          rx_ready,
  output logic          tx_valid,
  output logic [11:0]   tx_packet,
  input  logic          tx_ready,
  output logic [3:0]    stable_board [8][8],
  output logic          curr_player,
  output logic [7:0]    turn_time,
  output logic          rx_error,
  output logic          game_over,
  output logic          winner
);

  turn_ctrl_state_t state_q, state_d;
  board_t           board_q, board_d;
  logic             curr_player_q, curr_player_d;
  logic             game_over_q, game_over_d;
  logic             winner_q, winner_d;
  logic [11:0]      move_q, move_d;
  logic             from_local_q, from_local_d;

  logic             timer_run, timer_reload, timer_expired;
  logic             accept;
  logic [2:0]       old_x, old_y, new_x, new_y;
  logic [3:0]       moved_piece, placed_piece, captured_piece;

  turn_timer #(
    .CLK_HZ       (CLK_HZ),
    .TURN_SECONDS (TURN_SECONDS)
  ) u_turn_timer (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .run       (timer_run),
    .reload    (timer_reload),
    .turn_time (turn_time),
    .expired   (timer_expired)
  );

  assign timer_run = (state_q == WAIT_MOVE);
  assign {old_x, old_y, new_x, new_y} = move_q;

  // Piece to place on the destination, with auto-queen promotion.
  always_comb begin
    moved_piece    = board_q[old_x][old_y];
    captured_piece = board_q[new_x][new_y];
    placed_piece   = moved_piece;
    if (moved_piece == PAWN && new_x == 3'd7) begin
      placed_piece = QUEEN;
    end else if (moved_piece == PAWN + SIDE0_OFFSET && new_x == 3'd0) begin
      placed_piece = QUEEN + SIDE0_OFFSET;
    end
  end

  // Next-state, board update and handshake outputs.
  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    curr_player_d = curr_player_q;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    move_d        = move_q;
    from_local_d  = from_local_q;
    timer_reload  = 1'b0;
    accept        = 1'b0;
    rx_ready      = 1'b0;
    rx_error      = 1'b0;
    tx_valid      = 1'b0;

    if (sys_state != CHESS_SCREEN) begin
      // Leaving the chess screen aborts everything, including a pending send.
      state_d       = IDLE;
      board_d       = init_board();
      curr_player_d = 1'b1;
      game_over_d   = 1'b0;
      winner_d      = 1'b0;
      timer_reload  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          board_d       = init_board();
          curr_player_d = 1'b1;
          timer_reload  = 1'b1;
          state_d       = WAIT_MOVE;
        end
        WAIT_MOVE: begin
          if (curr_player_q == player) begin
            if (local_moved) begin
              accept       = 1'b1;
              move_d       = local_packet;
              from_local_d = 1'b1;
            end
          end else begin
            rx_ready = rx_valid;
            if (rx_valid) begin
              if (owns_piece(board_q[rx_packet[11:9]][rx_packet[8:6]], curr_player_q)) begin
                accept       = 1'b1;
                move_d       = rx_packet;
                from_local_d = 1'b0;
              end else begin
                rx_error = 1'b1;
              end
            end
          end
          // An accepted move beats a simultaneous timeout.
          if (accept) begin
            state_d = APPLY;
          end else if (timer_expired) begin
            game_over_d = 1'b1;
            winner_d    = ~curr_player_q;
            state_d     = GAME_END;
          end
        end
        APPLY: begin
          board_d[old_x][old_y] = PIECE_EMPTY;
          board_d[new_x][new_y] = placed_piece;
          if (captured_piece == KING || captured_piece == KING + SIDE0_OFFSET) begin
            game_over_d = 1'b1;
            winner_d    = curr_player_q;
          end
          if (from_local_q) begin
            state_d = SEND;
          end else if (captured_piece == KING || captured_piece == KING + SIDE0_OFFSET) begin
            state_d = GAME_END;
          end else begin
            curr_player_d = ~curr_player_q;
            timer_reload  = 1'b1;
            state_d       = WAIT_MOVE;
          end
        end
        SEND: begin
          tx_valid = 1'b1;
          if (tx_ready) begin
            if (game_over_q) begin
              state_d = GAME_END;
            end else begin
              curr_player_d = ~curr_player_q;
              timer_reload  = 1'b1;
              state_d       = WAIT_MOVE;
            end
          end
        end
        GAME_END: begin
          state_d = GAME_END;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      board_q       <= init_board();
      curr_player_q <= 1'b1;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      move_q        <= '0;
      from_local_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      board_q       <= board_d;
      curr_player_q <= curr_player_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      move_q        <= move_d;
      from_local_q  <= from_local_d;
    end
  end

  assign stable_board = board_q;
  assign curr_player  = curr_player_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;
  assign tx_packet    = move_q;

endmodule
